// File: rtl/whack_pkg.sv
// Constants and types shared by the whack-a-mole blocks (display, game controller, scorer).
package whack_pkg;

    localparam int NUM_MOLES    = 3;
    localparam int SCORE_DIGITS = 3;
    localparam int SPEED_W      = 28;
    localparam int BASE_TICKS   = 50_000_000;
    localparam int STEP_TICKS   = 5_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Clock cycles per mole at a given level; parameters guarantee no underflow.
    function automatic logic [SPEED_W-1:0] speed_for(input logic [2:0] lvl,
                                                      input int base,
                                                      input int step);
        return SPEED_W'(base) - SPEED_W'(lvl) * SPEED_W'(step);
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Saturating multi-digit BCD incrementer; clear wins over inc, holds at all-nines.
module bcd_counter3
    import whack_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        inc,
    output logic [4*SCORE_DIGITS-1:0]   value
);

    localparam logic [4*SCORE_DIGITS-1:0] MAX_VAL = {SCORE_DIGITS{4'h9}};

    logic [4*SCORE_DIGITS-1:0] value_nxt;
    logic                      carry;

    always_comb begin
        value_nxt = value;
        carry     = 1'b1;
        if (value != MAX_VAL) begin
            for (int d = 0; d < SCORE_DIGITS; d++) begin
                if (carry) begin
                    if (value[4*d +: 4] == 4'd9) begin
                        value_nxt[4*d +: 4] = 4'd0;
                    end else begin
                        value_nxt[4*d +: 4] = value[4*d +: 4] + 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/mole_hit_scorer.sv
// Judges debounced key presses against the lit mole, keeps score/misses/level
// and feeds the mole period back to the display controller.
module mole_hit_scorer
    import whack_pkg::*;
#(
    parameter int NUM_MOLES  = whack_pkg::NUM_MOLES,
    parameter int MAX_MISSES = 3,
    parameter int LEVEL_STEP = 10,
    parameter int MAX_LEVEL  = 7,
    parameter int BASE_TICKS = whack_pkg::BASE_TICKS,
    parameter int STEP_TICKS = whack_pkg::STEP_TICKS
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        game,
    input  logic [NUM_MOLES-1:0]        mole,
    input  logic [NUM_MOLES-1:0]        key_n,
    output logic                        turnoff,
    output logic [4*SCORE_DIGITS-1:0]   score_bcd,
    output logic [2:0]                  misses,
    output logic [2:0]                  level,
    output logic [SPEED_W-1:0]          speed,
    output logic                        game_over
);

    logic [NUM_MOLES-1:0] key_s1, key_s2, key_d, press;
    logic [NUM_MOLES-1:0] mole_prev;
    logic                 game_prev;
    logic                 hit_flag;
    logic [7:0]           hit_cnt;
    state_t               state, state_nxt;

    logic playing, rise, start;
    logic win_open, win_close, flag_eff;
    logic hit, wrong, escape, miss;

    assign press     = key_d & ~key_s2;
    assign playing   = (state == PLAY) && game;
    assign rise      = game && !game_prev;
    assign start     = (state == IDLE) && rise;
    assign win_open  = (|mole) && (mole != mole_prev);
    assign win_close = !(|mole) && (|mole_prev);

    // A window opening this cycle makes a press on the new mole a fresh hit.
    assign flag_eff  = hit_flag && !win_open;
    assign hit       = playing && (|(press & mole)) && !flag_eff;
    assign wrong     = (|(press & ~mole)) || (flag_eff && (|(press & mole)));
    assign escape    = win_close && !hit_flag;
    assign miss      = playing && !hit && (wrong || escape);
    assign game_over = (state == OVER);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = PLAY;
            PLAY:    if (!game) state_nxt = IDLE;
                     else if (miss && (misses == 3'(MAX_MISSES - 1))) state_nxt = OVER;
            OVER:    if (!game) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            key_s1    <= '1;
            key_s2    <= '1;
            key_d     <= '1;
            mole_prev <= '0;
            game_prev <= 1'b0;
            turnoff   <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_s1    <= key_n;
            key_s2    <= key_s1;
            key_d     <= key_s2;
            mole_prev <= mole;
            game_prev <= game;
            turnoff   <= hit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_flag <= 1'b0;
            misses   <= '0;
            hit_cnt  <= '0;
            level    <= '0;
        end else if (start) begin
            hit_flag <= 1'b0;
            misses   <= '0;
            hit_cnt  <= '0;
            level    <= '0;
        end else begin
            if (hit) begin
                hit_flag <= 1'b1;
            end else if (playing && win_open) begin
                hit_flag <= 1'b0;
            end
            if (miss) begin
                misses <= misses + 3'd1;
            end
            if (hit) begin
                if (hit_cnt == 8'(LEVEL_STEP - 1)) begin
                    hit_cnt <= '0;
                    if (level < 3'(MAX_LEVEL)) level <= level + 3'd1;
                end else begin
                    hit_cnt <= hit_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            speed <= SPEED_W'(BASE_TICKS);
        end else begin
            speed <= speed_for(level, BASE_TICKS, STEP_TICKS);
        end
    end

    bcd_counter3 u_score (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start),
        .inc     (hit),
        .value   (score_bcd)
    );

endmodule
